wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Round-robin arbiter for the shared WISHBONE bus inside the NIC. It drives the per-master grant consumed as gnt_wb_i by each wb_master_interface instance and by other bus masters.
- A grant is held for the whole bus cycle, from CYC_O high until CYC_O low. A one-cycle dead slot separates consecutive owners.
- A watchdog revokes the grant from a master whose slave never terminates, and signals an error for that master.

Parameters:
- N_MASTERS, 4, number of bus masters; must be ≥ 2.
- N_BITS_MASTER, 2, width of a master index; must satisfy 2^N_BITS_MASTER ≥ N_MASTERS.
- N_BITS_TIMEOUT, 8, width of the watchdog counter.
- TIMEOUT_LIMIT, 200, number of granted cycles without termination before revocation; 0 disables the watchdog; must be < 2^N_BITS_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cyc_i  in  N_MASTERS  CYC_O of each master; bit i = master i.
- ACK_I  in  1  bus termination from the selected slave.
- RTY_I  in  1  bus termination from the selected slave.
- ERR_I  in  1  bus termination from the selected slave.
- gnt_o  out  N_MASTERS  one-hot grant, registered; drives gnt_wb_i of each master.
- gnt_id_o  out  N_BITS_MASTER  index of the current owner; valid when bus_busy_o = 1.
- bus_busy_o  out  1  high while any gnt_o bit is set.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- timeout_id_o  out  N_BITS_MASTER  master revoked; held until the next timeout.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high: rst.
- Reset values: gnt_o = 0, gnt_id_o = 0, bus_busy_o = 0, timeout_o = 0, timeout_id_o = 0. Internal state: state = IDLE, last_owner = N_MASTERS-1, wd_cnt = 0.
- rst asserted mid-cycle: grant drops on the next edge. No termination bookkeeping is performed.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If cyc_i == 0, stay in IDLE.
  - Otherwise select the winner: the first i with cyc_i[i] = 1, searching from (last_owner+1) mod N_MASTERS upward with wrap.
  - Next edge: gnt_o = one-hot(winner), gnt_id_o = winner, last_owner = winner, wd_cnt = 0, state → GRANT.
  - Grant latency is 1 cycle from cyc_i rising.
- GRANT, owner releases:
  - If cyc_i[owner] = 0, next edge: gnt_o = 0, state → RELEASE.
  - A termination on the same cycle is ignored.
- GRANT, watchdog:
  - If ACK_I|RTY_I|ERR_I = 1, wd_cnt = 0 on the next edge.
  - Otherwise wd_cnt increments, saturating at 2^N_BITS_TIMEOUT-1.
  - If TIMEOUT_LIMIT ≠ 0, no termination this cycle, and wd_cnt == TIMEOUT_LIMIT-1: next edge gnt_o = 0, timeout_o = 1 for one cycle, timeout_id_o = owner, state → RELEASE.
  - Release by cyc_i dropping has priority over timeout on the same cycle (no timeout pulse).
- RELEASE:
  - gnt_o = 0 for exactly one cycle (bus turnaround).
  - Next edge → IDLE. No arbitration is performed in RELEASE.
  - Back-to-back ownership: the next grant is visible 2 cycles after the previous gnt_o falls.
- Revoked master: a master that keeps cyc_i high after a timeout remains a requester. Because last_owner points at it, every other requester is served first.
- Requests from non-owners during GRANT are simply pending. There is no preemption.
- gnt_o never has more than one bit set. bus_busy_o == |gnt_o.
- Out-of-range masters: if N_MASTERS < 2^N_BITS_MASTER, indices ≥ N_MASTERS are never selected.

Decomposition:
- NIC-defines.v gains:
  - `N_WB_MASTERS
  - `N_BITS_WB_MASTER
  - `WB_TIMEOUT_LIMIT
- Sub-module rr_priority_picker: combinational.
  - Inputs: request vector and last_owner.
  - Outputs: winner index and a found flag.
  - Isolated so that it can be unit-tested exhaustively and reused by the NIC output-port arbitration.

Test Plan:
- Reset then single request: rst 1 for 2 cycles, then cyc_i = 4'b0100 → gnt_o = 4'b0100, gnt_id_o = 2 one cycle later. After cyc_i drops, gnt_o = 0 on the next edge, and it stays 0 through RELEASE.
- Round-robin fairness: cyc_i = 4'b1111, each owner drops CYC after 3 granted cycles and re-raises it 1 cycle later → grant order 0,1,2,3,0. Each new grant comes 2 cycles after the previous gnt_o fall.
- Wrap-around: last_owner = 3, cyc_i = 4'b1001 → master 0 granted. Next arbitration → master 3.
- Watchdog: TIMEOUT_LIMIT = 5, master 1 holds CYC with no ACK → after 5 granted cycles: gnt_o = 0, timeout_o pulses 1 cycle, timeout_id_o = 1. With cyc_i = 4'b0011, master 0 is granted next.
- Watchdog reset and priority:
  - ACK_I on every 4th cycle with TIMEOUT_LIMIT = 5 → no timeout over 50 cycles.
  - cyc_i[owner] dropping on the expiry cycle → no timeout_o pulse.
- Reset mid-grant: master 2 owns the bus, rst pulses 1 cycle → gnt_o = 0 next edge. After rst, with cyc_i = 4'b0100, master 2 is re-granted (last_owner reset to 3).

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and defaults for the WISHBONE bus arbiter.
package wb_bus_arbiter_pkg;

   localparam int DEF_N_MASTERS      = 4;
   localparam int DEF_N_BITS_MASTER  = 2;
   localparam int DEF_N_BITS_TIMEOUT = 8;
   localparam int DEF_TIMEOUT_LIMIT  = 200;

   // IDLE arbitrates, GRANT holds one owner, RELEASE is the one-cycle bus turnaround.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   // Any of the three WISHBONE cycle terminations counts as slave activity.
   function automatic logic is_term(input logic ack, input logic rty, input logic err);
      return ack | rty | err;
   endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bus-side signals between the NIC masters/slaves and the arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface wb_bus_arbiter_if
   import wb_bus_arbiter_pkg::*;
#(
   parameter int N_MASTERS     = DEF_N_MASTERS,
   parameter int N_BITS_MASTER = DEF_N_BITS_MASTER
);

   logic [N_MASTERS-1:0]     cyc_i;
   logic                     ACK_I;
   logic                     RTY_I;
   logic                     ERR_I;
   logic [N_MASTERS-1:0]     gnt_o;
   logic [N_BITS_MASTER-1:0] gnt_id_o;
   logic                     bus_busy_o;
   logic                     timeout_o;
   logic [N_BITS_MASTER-1:0] timeout_id_o;

   modport master (
      output cyc_i, ACK_I, RTY_I, ERR_I,
      input  gnt_o, gnt_id_o, bus_busy_o, timeout_o, timeout_id_o
   );

   modport slave (
      input  cyc_i, ACK_I, RTY_I, ERR_I,
      output gnt_o, gnt_id_o, bus_busy_o, timeout_o, timeout_id_o
   );

endinterface

// File: rtl/wb_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester after last_owner, with wrap.
// Kept standalone so the NIC output-port arbitration can reuse it.
module rr_priority_picker
   import wb_bus_arbiter_pkg::*;
#(
   parameter int N_MASTERS     = DEF_N_MASTERS,
   parameter int N_BITS_MASTER = DEF_N_BITS_MASTER
) (
   input  logic [N_MASTERS-1:0]     req,
   input  logic [N_BITS_MASTER-1:0] last_owner,
   output logic [N_BITS_MASTER-1:0] winner,
   output logic                     found
);

   localparam logic [N_BITS_MASTER-1:0] LAST_IDX = N_BITS_MASTER'(N_MASTERS - 1);
   localparam logic [N_BITS_MASTER:0]   N_WIDE   = (N_BITS_MASTER + 1)'(N_MASTERS);

   logic [N_BITS_MASTER-1:0] start;
   logic [N_BITS_MASTER-1:0] offset;
   logic [N_BITS_MASTER:0]   sum;
   logic [2*N_MASTERS-1:0]   req_twice;
   logic [N_MASTERS-1:0]     req_rot;

   // Rotate the request vector so the search always starts at bit 0, take the
   // lowest set bit, then rotate the offset back into a master index.
   always_comb begin
      start     = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;
      req_twice = {req, req};
      req_rot   = N_MASTERS'(req_twice >> start);
      found     = 1'b0;
      offset    = '0;
      for (int j = N_MASTERS - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            found  = 1'b1;
            offset = N_BITS_MASTER'(j);
         end
      end
      sum = {1'b0, start} + {1'b0, offset};
      if (sum >= N_WIDE) begin
         sum = sum - N_WIDE;
      end
      winner = sum[N_BITS_MASTER-1:0];
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin owner arbitration for the shared NIC WISHBONE bus, with a
// watchdog that revokes the grant when the selected slave never terminates.
// N_BITS_MASTER must cover N_MASTERS and TIMEOUT_LIMIT must fit the counter.
module wb_bus_arbiter
   import wb_bus_arbiter_pkg::*;
#(
   parameter int N_MASTERS      = DEF_N_MASTERS,
   parameter int N_BITS_MASTER  = DEF_N_BITS_MASTER,
   parameter int N_BITS_TIMEOUT = DEF_N_BITS_TIMEOUT,
   parameter int TIMEOUT_LIMIT  = DEF_TIMEOUT_LIMIT
) (
   input logic            clk,
   input logic            rst,
   wb_bus_arbiter_if.slave bus
);

   localparam logic [N_BITS_TIMEOUT-1:0] WD_LAST =
      N_BITS_TIMEOUT'((TIMEOUT_LIMIT == 0) ? 0 : TIMEOUT_LIMIT - 1);
   localparam logic [N_BITS_TIMEOUT-1:0] WD_MAX  = '1;
   localparam logic [N_BITS_MASTER-1:0]  RESET_LAST = N_BITS_MASTER'(N_MASTERS - 1);

   arb_state_t               state, state_nxt;
   logic [N_BITS_MASTER-1:0] last_owner, last_owner_nxt;
   logic [N_BITS_TIMEOUT-1:0] wd_cnt, wd_cnt_nxt;

   logic [N_MASTERS-1:0]     gnt_q, gnt_nxt;
   logic [N_BITS_MASTER-1:0] gnt_id_q, gnt_id_nxt;
   logic                     busy_q, busy_nxt;
   logic                     timeout_q, timeout_nxt;
   logic [N_BITS_MASTER-1:0] timeout_id_q, timeout_id_nxt;

   logic [N_BITS_MASTER-1:0] pick_winner;
   logic                     pick_found;
   logic                     term;
   logic                     owner_req;
   logic                     wd_expired;

   rr_priority_picker #(
      .N_MASTERS     (N_MASTERS),
      .N_BITS_MASTER (N_BITS_MASTER)
   ) u_picker (
      .req        (bus.cyc_i),
      .last_owner (last_owner),
      .winner     (pick_winner),
      .found      (pick_found)
   );

   assign term       = is_term(bus.ACK_I, bus.RTY_I, bus.ERR_I);
   assign owner_req  = bus.cyc_i[gnt_id_q];
   assign wd_expired = (TIMEOUT_LIMIT != 0) && !term && (wd_cnt == WD_LAST);

   assign bus.gnt_o        = gnt_q;
   assign bus.gnt_id_o     = gnt_id_q;
   assign bus.bus_busy_o   = busy_q;
   assign bus.timeout_o    = timeout_q;
   assign bus.timeout_id_o = timeout_id_q;

   // State register plus every registered output and bookkeeping value; reset
   // drops the grant immediately and points last_owner at the top master so
   // master 0 is first in line afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_owner   <= RESET_LAST;
         wd_cnt       <= '0;
         gnt_q        <= '0;
         gnt_id_q     <= '0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
      end else begin
         state        <= state_nxt;
         last_owner   <= last_owner_nxt;
         wd_cnt       <= wd_cnt_nxt;
         gnt_q        <= gnt_nxt;
         gnt_id_q     <= gnt_id_nxt;
         busy_q       <= busy_nxt;
         timeout_q    <= timeout_nxt;
         timeout_id_q <= timeout_id_nxt;
      end
   end

   // Next-state decision: the owner letting go of CYC wins over a watchdog
   // expiry on the same cycle, and RELEASE always lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = GRANT;
         GRANT:   if (!owner_req || wd_expired) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the grant, watchdog and timeout reporting; a termination on
   // the cycle the owner releases is irrelevant because the grant is ending.
   always_comb begin
      gnt_nxt        = gnt_q;
      gnt_id_nxt     = gnt_id_q;
      last_owner_nxt = last_owner;
      wd_cnt_nxt     = wd_cnt;
      timeout_nxt    = 1'b0;
      timeout_id_nxt = timeout_id_q;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (pick_found) begin
               gnt_nxt[pick_winner] = 1'b1;
               gnt_id_nxt           = pick_winner;
               last_owner_nxt       = pick_winner;
               wd_cnt_nxt           = '0;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               gnt_nxt = '0;
            end else if (wd_expired) begin
               gnt_nxt        = '0;
               timeout_nxt    = 1'b1;
               timeout_id_nxt = gnt_id_q;
            end else if (term) begin
               wd_cnt_nxt = '0;
            end else if (wd_cnt != WD_MAX) begin
               wd_cnt_nxt = wd_cnt + 1'b1;
            end
         end
         RELEASE: gnt_nxt = '0;
         default: gnt_nxt = '0;
      endcase
      busy_nxt = |gnt_nxt;
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed plus randomized bench for wb_bus_arbiter against a cycle-level
// model of ownership, turnaround and silent-cycle counting.
module tb_wb_bus_arbiter;
   import wb_bus_arbiter_pkg::*;

   localparam int NM       = 4;
   localparam int NB       = 2;
   localparam int TO_LIMIT = 5;

   logic clk;
   logic rst;

   int nAssert = 0;
   int nFail   = 0;

   // Reference model: owner index (-1 = none), turnaround cycles left,
   // last owner and number of consecutive unterminated granted cycles.
   int mOwner  = -1;
   int mCool   = 0;
   int mLast   = NM - 1;
   int mSilent = 0;
   logic [3:0] expGnt   = '0;
   logic [1:0] expId    = '0;
   logic       expTo    = 1'b0;
   logic [1:0] expToId  = '0;

   wb_bus_arbiter_if #(.N_MASTERS(NM), .N_BITS_MASTER(NB)) bus ();

   wb_bus_arbiter #(
      .N_MASTERS      (NM),
      .N_BITS_MASTER  (NB),
      .N_BITS_TIMEOUT (8),
      .TIMEOUT_LIMIT  (TO_LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelStep(input logic [3:0] cyc, input logic term, input logic rstv);
      int c;
      if (rstv) begin
         mOwner  = -1;
         mCool   = 0;
         mLast   = NM - 1;
         mSilent = 0;
         expId   = '0;
         expTo   = 1'b0;
         expToId = '0;
      end else begin
         expTo = 1'b0;
         if (mOwner >= 0) begin
            if (!cyc[mOwner]) begin
               mOwner = -1;
               mCool  = 1;
            end else if (!term && (mSilent + 1 >= TO_LIMIT)) begin
               expTo   = 1'b1;
               expToId = 2'(mOwner);
               mOwner  = -1;
               mCool   = 1;
            end else begin
               mSilent = term ? 0 : mSilent + 1;
            end
         end else if (mCool > 0) begin
            mCool--;
         end else begin
            for (int k = 1; k <= NM; k++) begin
               c = (mLast + k) % NM;
               if (mOwner < 0 && cyc[c]) begin
                  mOwner  = c;
                  mLast   = c;
                  mSilent = 0;
                  expId   = 2'(c);
               end
            end
         end
      end
      expGnt = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
   endtask

   task automatic modelCompare();
      checkOutput("gnt_o",        32'(bus.gnt_o),        32'(expGnt));
      checkOutput("gnt_id_o",     32'(bus.gnt_id_o),     32'(expId));
      checkOutput("bus_busy_o",   32'(bus.bus_busy_o),   32'(expGnt != 4'b0000));
      checkOutput("timeout_o",    32'(bus.timeout_o),    32'(expTo));
      checkOutput("timeout_id_o", 32'(bus.timeout_id_o), 32'(expToId));
   endtask

   // One clock of stimulus: drive on the falling edge, advance the model on
   // the rising edge, compare just after it.
   task automatic applyStimulus(input logic [3:0] cyc, input logic ack, input logic rty,
                                input logic err, input logic rstv);
      @(negedge clk);
      bus.cyc_i = cyc;
      bus.ACK_I = ack;
      bus.RTY_I = rty;
      bus.ERR_I = err;
      rst       = rstv;
      @(posedge clk);
      modelStep(cyc, ack | rty | err, rstv);
      #1;
      modelCompare();
   endtask

   // Directed scenarios followed by a randomized soak.
   initial begin
      int heldCnt;
      int gapCnt;
      int grantIdx;
      int order [5];
      logic [3:0] cycv;
      logic [3:0] cycState;

      order = '{0, 1, 2, 3, 0};
      rst       = 1'b1;
      bus.cyc_i = '0;
      bus.ACK_I = 1'b0;
      bus.RTY_I = 1'b0;
      bus.ERR_I = 1'b0;

      // Reset then a single request from master 2.
      applyStimulus(4'b0000, 0, 0, 0, 1);
      applyStimulus(4'b0000, 0, 0, 0, 1);
      checkOutput("reset_gnt", 32'(bus.gnt_o), 32'h0);
      checkOutput("reset_busy", 32'(bus.bus_busy_o), 32'h0);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      checkOutput("single_gnt", 32'(bus.gnt_o), 32'h4);
      checkOutput("single_id", 32'(bus.gnt_id_o), 32'h2);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 0, 0, 0);
      checkOutput("single_drop", 32'(bus.gnt_o), 32'h0);
      applyStimulus(4'b0000, 0, 0, 0, 0);
      checkOutput("single_release", 32'(bus.gnt_o), 32'h0);

      // Round-robin fairness with all four masters requesting.
      applyStimulus(4'b0000, 0, 0, 0, 1);
      heldCnt  = 0;
      gapCnt   = 0;
      grantIdx = 0;
      for (int c = 0; c < 60 && grantIdx < 5; c++) begin
         cycv = 4'b1111;
         if (heldCnt == 3 && mOwner >= 0) cycv = cycv & ~(4'b0001 << mOwner);
         applyStimulus(cycv, 0, 0, 0, 0);
         if (mOwner >= 0) begin
            if (heldCnt == 0) begin
               checkOutput("rr_order", 32'(bus.gnt_id_o), 32'(order[grantIdx]));
               if (grantIdx > 0) checkOutput("rr_gap", 32'(gapCnt), 32'd2);
               grantIdx++;
            end
            heldCnt++;
            gapCnt = 0;
         end else begin
            heldCnt = 0;
            gapCnt++;
         end
      end
      checkOutput("rr_grants_seen", 32'(grantIdx), 32'd5);

      // Wrap-around from last_owner 3.
      applyStimulus(4'b0000, 0, 0, 0, 1);
      applyStimulus(4'b1001, 0, 0, 0, 0);
      checkOutput("wrap_first", 32'(bus.gnt_o), 32'h1);
      applyStimulus(4'b1000, 0, 0, 0, 0);
      applyStimulus(4'b1001, 0, 0, 0, 0);
      applyStimulus(4'b1001, 0, 0, 0, 0);
      checkOutput("wrap_second", 32'(bus.gnt_id_o), 32'h3);

      // Watchdog revokes master 1, then master 0 is served.
      applyStimulus(4'b0000, 0, 0, 0, 1);
      applyStimulus(4'b0010, 0, 0, 0, 0);
      checkOutput("wd_grant", 32'(bus.gnt_o), 32'h2);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0011, 0, 0, 0, 0);
      checkOutput("wd_still_held", 32'(bus.gnt_o), 32'h2);
      applyStimulus(4'b0011, 0, 0, 0, 0);
      checkOutput("wd_revoke", 32'(bus.gnt_o), 32'h0);
      checkOutput("wd_pulse", 32'(bus.timeout_o), 32'h1);
      checkOutput("wd_id", 32'(bus.timeout_id_o), 32'h1);
      applyStimulus(4'b0011, 0, 0, 0, 0);
      checkOutput("wd_pulse_end", 32'(bus.timeout_o), 32'h0);
      applyStimulus(4'b0011, 0, 0, 0, 0);
      checkOutput("wd_next_owner", 32'(bus.gnt_o), 32'h1);

      // Periodic ACK keeps the watchdog from firing.
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) begin
         applyStimulus(4'b0010, (i % 4) == 3, 0, 0, 0);
         checkOutput("wd_ack_no_timeout", 32'(bus.timeout_o), 32'h0);
      end

      // Owner drops CYC on the expiry cycle: release wins, no pulse.
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 0, 0, 0, 0);
      applyStimulus(4'b0000, 0, 0, 0, 0);
      checkOutput("wd_release_prio_pulse", 32'(bus.timeout_o), 32'h0);
      checkOutput("wd_release_prio_gnt", 32'(bus.gnt_o), 32'h0);

      // Reset in the middle of a grant held by master 2.
      applyStimulus(4'b0000, 0, 0, 0, 0);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      checkOutput("midrst_owned", 32'(bus.gnt_o), 32'h4);
      applyStimulus(4'b0100, 0, 0, 0, 1);
      checkOutput("midrst_drop", 32'(bus.gnt_o), 32'h0);
      applyStimulus(4'b0100, 0, 0, 0, 0);
      checkOutput("midrst_regrant", 32'(bus.gnt_o), 32'h4);
      checkOutput("midrst_regrant_id", 32'(bus.gnt_id_o), 32'h2);

      // Randomized soak: slowly changing requests, sparse terminations, rare resets.
      cycState = 4'(($urandom() & 32'hF));
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < NM; b++) begin
            if ($urandom_range(0, 5) == 0) cycState = cycState ^ (4'b0001 << b);
         end
         applyStimulus(cycState,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 19) == 0,
                       $urandom_range(0, 19) == 0,
                       $urandom_range(0, 149) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
